// File: rtl/user_pixel_buffer_pkg.sv
// Shared definitions for the user-domain pixel buffer.
// Holds the OBI request/response struct types used on the CPU port, the
// register-window offsets, the STATUS/CTRL bit positions, the bit that
// selects the register window and the default storage depth.
package user_pixel_buffer_pkg;

   localparam int unsigned OBI_AW  = 32;
   localparam int unsigned OBI_DW  = 32;
   localparam int unsigned OBI_IDW = 4;

   typedef struct packed {
      logic [OBI_AW-1:0]   addr;
      logic                we;
      logic [OBI_DW/8-1:0] be;
      logic [OBI_DW-1:0]   wdata;
      logic [OBI_IDW-1:0]  aid;
   } upb_obi_a_t;

   typedef struct packed {
      logic       req;
      upb_obi_a_t a;
   } upb_obi_req_t;

   typedef struct packed {
      logic [OBI_DW-1:0]  rdata;
      logic [OBI_IDW-1:0] rid;
      logic               err;
   } upb_obi_r_t;

   typedef struct packed {
      logic       gnt;
      logic       rvalid;
      upb_obi_r_t r;
   } upb_obi_rsp_t;

   // addr[WIN_SEL_BIT]=0 selects pixel storage, =1 selects registers
   localparam int unsigned WIN_SEL_BIT = 8;

   // register word offsets (addr[3:2])
   localparam logic [1:0] REG_STATUS = 2'd0;
   localparam logic [1:0] REG_CTRL   = 2'd1;

   // STATUS fields: [15:0] holds the served-read count
   localparam int unsigned ST_ERR_BIT = 16;
   localparam int unsigned ST_VLD_BIT = 17;

   // CTRL fields
   localparam int unsigned CTRL_LOCK_BIT = 0;
   localparam int unsigned CTRL_CLR_BIT  = 1;

   localparam int unsigned DEFAULT_DEPTH = 64;

endpackage

// File: rtl/user_pixel_rom_port.sv
// Byte read port serving the accelerator's ROM fetch interface.
// Ports:
//   clk_i, rst_i      clock / asynchronous active-high reset
//   rom_req_i         level-held read request
//   rom_addr_i        requested byte index
//   clr_i             clears the read count and the range-error sticky
//   rd_addr_o         storage read-mux select (byte index)
//   rd_data_i         storage byte at rd_addr_o
//   rom_data_o        returned byte, held while rom_valid_o is low
//   rom_valid_o       one-cycle response pulse
//   count_o           accepted-read count (wraps)
//   err_o             sticky out-of-range flag
module user_pixel_rom_port
   import user_pixel_buffer_pkg::*;
#(
   parameter int unsigned Depth = DEFAULT_DEPTH,
   parameter int unsigned AW    = $clog2(Depth)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          rom_req_i,
   input  logic [31:0]   rom_addr_i,
   input  logic          clr_i,
   output logic [AW-1:0] rd_addr_o,
   input  logic [7:0]    rd_data_i,
   output logic [7:0]    rom_data_o,
   output logic          rom_valid_o,
   output logic [15:0]   count_o,
   output logic          err_o
);

   logic        valid_q, valid_d;
   logic [7:0]  data_q, data_d;
   logic [15:0] count_q, count_d;
   logic        err_q, err_d;
   logic        accept, in_range;

   // A pending response blocks the next accept, so a held request is
   // answered at most every other cycle.
   assign accept    = rom_req_i && !valid_q;
   assign in_range  = rom_addr_i < 32'(Depth);
   assign rd_addr_o = rom_addr_i[AW-1:0];

   always_comb begin
      valid_d = accept;
      data_d  = data_q;
      count_d = count_q;
      err_d   = err_q;
      if (accept) begin
         data_d  = in_range ? rd_data_i : 8'h00;
         count_d = count_q + 16'd1;
         if (!in_range) err_d = 1'b1;
      end
      // a clear in the same cycle as an accept discards that accept's effect
      if (clr_i) begin
         count_d = '0;
         err_d   = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   assign rom_data_o  = data_q;
   assign rom_valid_o = valid_q;
   assign count_o     = count_q;
   assign err_o       = err_q;

endmodule

// File: rtl/user_pixel_buffer.sv
// Writable pixel store replacing a fixed ROM in the user domain.
// The CPU loads and inspects pixels through an OBI subordinate port; the
// accelerator reads single bytes through the ROM fetch port.
// Ports:
//   clk_i, rst_i   clock / asynchronous active-high reset
//   obi_req_i      OBI request (req, addr/we/be/wdata/aid)
//   obi_rsp_o      OBI response (gnt, rvalid, rdata/rid/err)
//   rom_req_i      accelerator byte request, level-held
//   rom_addr_i     accelerator byte index
//   rom_data_o     returned pixel
//   rom_valid_o    response pulse
module user_pixel_buffer
   import user_pixel_buffer_pkg::*;
#(
   parameter type         obi_req_t = upb_obi_req_t,
   parameter type         obi_rsp_t = upb_obi_rsp_t,
   parameter int unsigned Depth     = DEFAULT_DEPTH
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  obi_req_t    obi_req_i,
   output obi_rsp_t    obi_rsp_o,
   input  logic        rom_req_i,
   input  logic [31:0] rom_addr_i,
   output logic [7:0]  rom_data_o,
   output logic        rom_valid_o
);

   localparam int unsigned AW    = $clog2(Depth);
   localparam int unsigned WORDS = Depth / 4;

   logic [Depth-1:0][7:0] mem_q;
   logic                  lock_q;

   // registered OBI request, processed one cycle after the grant
   logic               req_q, we_q;
   logic [8:2]         addr_q;
   logic [3:0]         be_q;
   logic [31:0]        wdata_q;
   logic [OBI_IDW-1:0] aid_q;

   logic                 win_wr, ctrl_wr, clr;
   logic [31:0]          rdata;
   logic                 err;
   logic [3:0][AW-1:0]   win_idx;
   logic                 word_ok;
   logic [AW-1:0]        rom_rd_addr;
   logic [15:0]          rd_count;
   logic                 rd_err;

   logic unused_addr;
   assign unused_addr = ^{obi_req_i.a.addr[31:9], obi_req_i.a.addr[1:0]};

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         aid_q   <= '0;
      end else begin
         req_q <= obi_req_i.req;
         if (obi_req_i.req) begin
            we_q    <= obi_req_i.a.we;
            addr_q  <= obi_req_i.a.addr[8:2];
            be_q    <= obi_req_i.a.be;
            wdata_q <= obi_req_i.a.wdata;
            aid_q   <= obi_req_i.a.aid;
         end
      end
   end

   assign word_ok = {1'b0, addr_q[7:2]} < 7'(WORDS);

   always_comb begin
      for (int i = 0; i < 4; i++) win_idx[i] = AW'({addr_q[7:2], 2'(i)});
   end

   always_comb begin
      win_wr  = 1'b0;
      ctrl_wr = 1'b0;
      rdata   = '0;
      err     = 1'b0;
      if (req_q) begin
         if (!addr_q[WIN_SEL_BIT]) begin
            if (!word_ok) begin
               err = 1'b1;
            end else if (we_q) begin
               if (lock_q) err = 1'b1;
               else        win_wr = 1'b1;
            end else begin
               for (int i = 0; i < 4; i++) rdata[8*i +: 8] = mem_q[win_idx[i]];
            end
         end else begin
            case (addr_q[3:2])
               REG_STATUS: begin
                  if (we_q) err = 1'b1;
                  else begin
                     rdata[15:0]       = rd_count;
                     rdata[ST_ERR_BIT] = rd_err;
                     rdata[ST_VLD_BIT] = rom_valid_o;
                  end
               end
               REG_CTRL: begin
                  if (we_q) ctrl_wr = 1'b1;
                  else      rdata[CTRL_LOCK_BIT] = lock_q;
               end
               default: err = 1'b1;
            endcase
         end
      end
   end

   // CLR is a write-only strobe; it never occupies a register bit
   assign clr = ctrl_wr && be_q[0] && wdata_q[CTRL_CLR_BIT];

   always_comb begin
      obi_rsp_o         = '0;
      obi_rsp_o.gnt     = obi_req_i.req;
      obi_rsp_o.rvalid  = req_q;
      obi_rsp_o.r.rdata = rdata;
      obi_rsp_o.r.rid   = aid_q;
      obi_rsp_o.r.err   = err;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         mem_q  <= '0;
         lock_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++)
            if (win_wr && be_q[i]) mem_q[win_idx[i]] <= wdata_q[8*i +: 8];
         if (ctrl_wr && be_q[0]) lock_q <= wdata_q[CTRL_LOCK_BIT];
      end
   end

   // ROM reads sample mem_q before this cycle's OBI write lands
   user_pixel_rom_port #(
      .Depth (Depth)
   ) u_rom_port (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .rom_req_i   (rom_req_i),
      .rom_addr_i  (rom_addr_i),
      .clr_i       (clr),
      .rd_addr_o   (rom_rd_addr),
      .rd_data_i   (mem_q[rom_rd_addr]),
      .rom_data_o  (rom_data_o),
      .rom_valid_o (rom_valid_o),
      .count_o     (rd_count),
      .err_o       (rd_err)
   );

endmodule

// File: tb/tb_user_pixel_buffer.sv
module tb_user_pixel_buffer;
   import user_pixel_buffer_pkg::*;

   logic         clk, rst;
   upb_obi_req_t req;
   upb_obi_rsp_t rsp;
   logic         rom_req;
   logic [31:0]  rom_addr;
   logic [7:0]   rom_data;
   logic         rom_valid;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  rid;
   } obi_exp_t;

   obi_exp_t   obi_q[$];
   logic [7:0] rom_q[$];
   int         n_chk, n_fail, rom_pulses;
   logic [3:0] aid_cnt;

   user_pixel_buffer #(.Depth(64)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .obi_req_i   (req),
      .obi_rsp_o   (rsp),
      .rom_req_i   (rom_req),
      .rom_addr_i  (rom_addr),
      .rom_data_o  (rom_data),
      .rom_valid_o (rom_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   task automatic obi_drive(input logic [31:0] addr, input logic we, input logic [3:0] be,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      obi_exp_t e;
      req.req     = 1'b1;
      req.a.addr  = addr;
      req.a.we    = we;
      req.a.be    = be;
      req.a.wdata = wdata;
      req.a.aid   = aid_cnt;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.rid   = aid_cnt;
      obi_q.push_back(e);
      aid_cnt = aid_cnt + 4'd1;
      @(posedge clk); #1;
      req.req = 1'b0;
   endtask

   task automatic obi(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
      obi_drive(addr, we, be, wdata, exp_rdata, exp_err);
      @(posedge clk); #1;
   endtask

   task automatic rom(input logic [31:0] addr, input logic [7:0] exp);
      rom_req  = 1'b1;
      rom_addr = addr;
      rom_q.push_back(exp);
      @(posedge clk); #1;
      rom_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      n_chk = 0; n_fail = 0; rom_pulses = 0; aid_cnt = '0;
      rst = 1'b1; req = '0; rom_req = 1'b0; rom_addr = '0;

      // monitor: pops an expectation whenever the DUT presents a response
      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (req.req) chk("obi_gnt", 32'(rsp.gnt), 32'd1);
               if (rsp.rvalid) begin
                  if (obi_q.size() == 0) begin
                     n_chk++; n_fail++;
                     $display("FAIL obi_unexpected: got rvalid=1 expected no response");
                  end else begin
                     obi_exp_t e;
                     e = obi_q.pop_front();
                     chk("obi_rdata", rsp.r.rdata, e.rdata);
                     chk("obi_err_rid", {27'd0, rsp.r.err, rsp.r.rid}, {27'd0, e.err, e.rid});
                  end
               end
               if (rom_valid) begin
                  rom_pulses++;
                  if (rom_q.size() == 0) begin
                     n_chk++; n_fail++;
                     $display("FAIL rom_unexpected: got rom_valid_o=1 expected no response");
                  end else begin
                     logic [7:0] d;
                     d = rom_q.pop_front();
                     chk("rom_data", 32'(rom_data), 32'(d));
                  end
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_rom_valid", 32'(rom_valid), 32'd0);
      chk("rst_rom_data", 32'(rom_data), 32'd0);
      chk("rst_rvalid", 32'(rsp.rvalid), 32'd0);
      @(posedge clk); #1;
      obi(32'h100, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);          // STATUS after reset
      obi(32'h0,   1'b0, 4'hF, 32'h0, 32'h0, 1'b0);          // storage after reset

      // basic write / read / ROM fetch
      obi(32'h0, 1'b1, 4'hF, 32'h44332211, 32'h0, 1'b0);
      obi(32'h0, 1'b0, 4'hF, 32'h0, 32'h44332211, 1'b0);
      rom(32'd2, 8'h33);

      // clear count, then a held request stepping through addresses 0..8
      obi(32'h104, 1'b1, 4'hF, 32'h2, 32'h0, 1'b0);
      rom_pulses = 0;
      rom_req = 1'b1;
      for (int k = 0; k < 9; k++) begin
         rom_addr = k;
         rom_q.push_back(k == 0 ? 8'h11 : k == 1 ? 8'h22 : k == 2 ? 8'h33 : k == 3 ? 8'h44 : 8'h00);
         @(posedge clk); #1;      // valid cycle: address changes here
         rom_addr = k + 1;
         @(posedge clk); #1;
      end
      rom_req = 1'b0;
      @(posedge clk); #1;
      chk("held_req_pulses", rom_pulses, 9);
      obi(32'h100, 1'b0, 4'hF, 32'h0, 32'h9, 1'b0);

      // byte-enable write; ROM reads the same byte in the commit cycle
      obi_drive(32'h0, 1'b1, 4'h2, 32'h0000AB00, 32'h0, 1'b0);
      rom_req = 1'b1; rom_addr = 32'd1; rom_q.push_back(8'h22);
      @(posedge clk); #1;
      rom_req = 1'b0;
      @(posedge clk); #1;
      obi(32'h0, 1'b0, 4'hF, 32'h0, 32'h4433AB11, 1'b0);

      // LOCK blocks window writes but not the ROM port
      obi(32'h104, 1'b1, 4'hF, 32'h1, 32'h0, 1'b0);
      obi(32'h0, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h0, 1'b1);
      obi(32'h0, 1'b0, 4'hF, 32'h0, 32'h4433AB11, 1'b0);
      rom(32'd0, 8'h11);
      obi(32'h104, 1'b0, 4'hF, 32'h0, 32'h1, 1'b0);
      obi(32'h104, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0);
      obi(32'h4, 1'b1, 4'hF, 32'h88776655, 32'h0, 1'b0);
      obi(32'h4, 1'b0, 4'hF, 32'h0, 32'h88776655, 1'b0);

      // range errors and register-map errors
      rom(32'd64, 8'h00);
      obi(32'h100, 1'b0, 4'hF, 32'h0, 32'h0001000C, 1'b0);   // 12 reads, sticky set
      obi(32'h40,  1'b0, 4'hF, 32'h0, 32'h0, 1'b1);          // word 16 out of window
      obi(32'h3C,  1'b0, 4'hF, 32'h0, 32'h0, 1'b0);          // last word in window
      obi(32'h108, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
      obi(32'h100, 1'b1, 4'hF, 32'h5, 32'h0, 1'b1);          // STATUS is read-only
      obi(32'h104, 1'b1, 4'hF, 32'h3, 32'h0, 1'b0);          // LOCK + CLR
      obi(32'h100, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      obi(32'h104, 1'b0, 4'hF, 32'h0, 32'h1, 1'b0);
      obi(32'h104, 1'b1, 4'hF, 32'h0, 32'h0, 1'b0);

      // reset during a ROM accept and an OBI request: both dropped
      rst = 1'b1; rom_req = 1'b1; rom_addr = 32'd0;
      req.req = 1'b1; req.a.addr = 32'h0; req.a.we = 1'b0;
      @(posedge clk); #1;
      rom_req = 1'b0; req.req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (2) @(posedge clk); #1;
      obi(32'h0,   1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      obi(32'h4,   1'b0, 4'hF, 32'h0, 32'h0, 1'b0);
      obi(32'h10C, 1'b0, 4'hF, 32'h0, 32'h0, 1'b1);
      obi(32'h100, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0);

      repeat (3) @(posedge clk);
      chk("obi_queue_drained", obi_q.size(), 0);
      chk("rom_queue_drained", rom_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
